// File: rtl/alu_pkg.sv
// alu_pkg: shared nibble width, FSM states, flag bit positions and saturation helpers
package alu_pkg;
  localparam int NIB_W = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  // Largest positive two's-complement value of width w, LSB-aligned in 32 bits.
  function automatic logic [31:0] sat_pos(input int w);
    return (32'h1 << (w - 1)) - 32'h1;
  endfunction
  // Most negative two's-complement value of width w, LSB-aligned in 32 bits.
  function automatic logic [31:0] sat_neg(input int w);
    return 32'h1 << (w - 1);
  endfunction
endpackage

// File: rtl/alu_flag_calc.sv
// alu_flag_calc: per-nibble carry, signed-overflow and sign flags from the adder outputs
module alu_flag_calc
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] i_s,
  input  logic             i_cout,
  input  logic             i_am3,
  input  logic             i_bm3,
  output logic             o_c,
  output logic             o_v,
  output logic             o_n
);
  assign o_c = i_cout;
  assign o_n = i_s[NIB_W-1];
  assign o_v = (i_am3 == i_bm3) & (i_s[NIB_W-1] != i_am3);
endmodule

// File: rtl/alu_postprocess.sv
// alu_postprocess: assembles adder nibbles into a word with Z/C/V/N flags behind a valid/ready output (ALU_SAT_EN enables signed saturation on overflow)
module alu_postprocess
  import alu_pkg::*;
#(
  parameter int NIB = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NIB_W-1:0]    S,
  input  logic                cout,
  input  logic                AM3,
  input  logic                BM3,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic                cin_next,
  output logic [NIB_W*NIB-1:0] R,
  output logic [3:0]          flags,
  output logic                out_valid,
  input  logic                out_ready
);
  localparam int W = NIB_W * NIB;
  localparam int CW = $clog2(NIB + 1);
`ifdef ALU_SAT_EN
  localparam logic [W-1:0] SAT_POS = W'(sat_pos(W));
  localparam logic [W-1:0] SAT_NEG = W'(sat_neg(W));
`endif
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_r;
  logic [3:0]     r_flags;
  logic           r_cin;
  logic [CW-1:0]  w_idx;
  logic           w_last;
  logic [W-1:0]   w_r_wr;
  logic [W-1:0]   w_r_fin;
  logic [3:0]     w_flags;
  logic           w_c;
  logic           w_v;
  logic           w_n;
  alu_flag_calc u_flag (
    .i_s    (S),
    .i_cout (cout),
    .i_am3  (AM3),
    .i_bm3  (BM3),
    .o_c    (w_c),
    .o_v    (w_v),
    .o_n    (w_n)
  );
  assign in_ready  = r_state != DONE;
  assign out_valid = r_state == DONE;
  assign cin_next  = r_cin;
  assign R         = r_r;
  assign flags     = r_flags;
  assign w_idx     = (r_state == IDLE) ? '0 : r_cnt;
  assign w_last    = in_last | (w_idx == CW'(NIB - 1));
  // Merge the incoming nibble into the word (a fresh word starts from zero so missing nibbles read as 0), then apply saturation and flags.
  always_comb begin
    w_r_wr = (r_state == IDLE) ? '0 : r_r;
    for (int i = 0; i < NIB; i++)
      if (w_idx == CW'(i)) w_r_wr[NIB_W*i +: NIB_W] = S;
`ifdef ALU_SAT_EN
    w_r_fin = w_v ? (w_n ? SAT_POS : SAT_NEG) : w_r_wr;
    w_flags[FLAG_N] = w_v ? ~w_n : w_n;
`else
    w_r_fin = w_r_wr;
    w_flags[FLAG_N] = w_n;
`endif
    w_flags[FLAG_Z] = w_r_fin == '0;
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
  end
  // Nibble accept/assemble FSM; DONE holds the word until downstream takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_r     <= '0;
      r_flags <= '0;
      r_cin   <= 1'b0;
    end else if (r_state == DONE) begin
      if (out_ready) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_cin   <= 1'b0;
      end
    end else if (in_valid) begin
      r_r     <= w_last ? w_r_fin : w_r_wr;
      r_flags <= w_last ? w_flags : r_flags;
      r_cnt   <= w_idx + CW'(1);
      r_cin   <= cout;
      r_state <= w_last ? DONE : ACCUM;
    end
  end
endmodule

// File: tb/tb_alu_postprocess.sv
// tb_alu_postprocess: randomized word-level checking of alu_postprocess against an operand-arithmetic reference model
module tb_alu_postprocess;
  localparam int NIB = 2;
  localparam int W = 4 * NIB;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   S;
  logic         cout;
  logic         AM3;
  logic         BM3;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         cin_next;
  logic [W-1:0] R;
  logic [3:0]   flags;
  logic         out_valid;
  logic         out_ready;
  int n_cmp = 0;
  int n_bad = 0;
  alu_postprocess #(.NIB(NIB)) dut (
    .clk       (clk),
    .reset     (reset),
    .S         (S),
    .cout      (cout),
    .AM3       (AM3),
    .BM3       (BM3),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .cin_next  (cin_next),
    .R         (R),
    .flags     (flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs;
    in_valid = 1'b0;
    in_last  = 1'b0;
    S        = 4'h0;
    cout     = 1'b0;
    AM3      = 1'b0;
    BM3      = 1'b0;
  endtask
  // Reference: k-nibble two's-complement add of a and b, flags over that width, optional full-width saturation.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input int k,
                       output logic [W-1:0] r, output logic [3:0] f);
    longint unsigned m, sum, rr, sa, sb, sr, c, v;
    m   = (64'd1 << (4 * k)) - 64'd1;
    sum = (64'(a) & m) + (64'(b) & m);
    rr  = sum & m;
    c   = sum >> (4 * k);
    sa  = (64'(a) >> (4 * k - 1)) & 64'd1;
    sb  = (64'(b) >> (4 * k - 1)) & 64'd1;
    sr  = (rr >> (4 * k - 1)) & 64'd1;
    v   = ((sa == sb) && (sr != sa)) ? 64'd1 : 64'd0;
`ifdef ALU_SAT_EN
    if (v == 64'd1) begin
      rr = (sr == 64'd1) ? (64'd1 << (W - 1)) - 64'd1 : (64'd1 << (W - 1));
      sr = sr ^ 64'd1;
    end
`endif
    r = W'(rr);
    f = {rr == 64'd0, c[0], v[0], sr[0]};
  endtask
  // Drives k nibbles of a+b (ripple carry kept by the bench), holds DONE for `hold` cycles under junk input, then releases it.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input int k,
                           input bit last_flag, input int hold);
    logic [W-1:0] er;
    logic [3:0]   ef;
    logic [4:0]   t;
    logic [3:0]   an, bn;
    logic         c;
    model(a, b, k, er, ef);
    c = 1'b0;
    check("cin_start", cin_next, 0);
    for (int i = 0; i < k; i++) begin
      check("in_ready_acc", in_ready, 1);
      an = a[4*i +: 4];
      bn = b[4*i +: 4];
      t  = 5'(an) + 5'(bn) + 5'(c);
      S = t[3:0]; cout = t[4]; AM3 = an[3]; BM3 = bn[3];
      in_valid = 1'b1;
      in_last  = last_flag && (i == k - 1);
      c = t[4];
      @(negedge clk);
      check("cin_next", cin_next, c);
      if (i < k - 1) check("out_valid_mid", out_valid, 0);
    end
    check("out_valid", out_valid, 1);
    check("in_ready_done", in_ready, 0);
    check("R", R, er);
    check("flags", flags, ef);
    for (int h = 0; h < hold; h++) begin
      S = 4'($urandom); cout = 1'($urandom); AM3 = 1'($urandom); BM3 = 1'($urandom);
      in_valid = 1'b1; in_last = 1'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_R", R, er);
      check("hold_flags", flags, ef);
      check("hold_cin", cin_next, c);
    end
    idle_inputs();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
    check("release_cin", cin_next, 0);
  endtask
  initial begin
    logic [W-1:0] ra, rb;
    int k;
    bit lf;
    idle_inputs();
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_R", R, 0);
    check("rst_flags", flags, 0);
    check("rst_cin", cin_next, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    reset = 1'b0;
    @(negedge clk);
    send_word(8'h3C, 8'h45, 2, 1'b1, 0);
    send_word(8'h01, 8'hFF, 2, 1'b1, 3);
    send_word(8'h05, 8'h00, 1, 1'b1, 1);
    send_word(8'hA7, 8'h6E, 2, 1'b0, 2);
    S = 4'h1; cout = 1'b1; AM3 = 1'b1; BM3 = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    @(negedge clk);
    check("mid_cin", cin_next, 1);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_R", R, 0);
    check("midrst_flags", flags, 0);
    check("midrst_cin", cin_next, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_valid", out_valid, 0);
    send_word(8'h12, 8'h34, 2, 1'b1, 0);
    for (int n = 0; n < 60; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      k  = $urandom_range(1, NIB);
      lf = (k < NIB) ? 1'b1 : 1'($urandom);
      send_word(ra, rb, k, lf, $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
